// File: rtl/data_status_pipe_hs_pkg.sv
// Shared constants and helpers for the data/status valid-ready pipeline.
// No bus typedefs: payload widths are per-instance parameters.
package data_status_pipe_hs_pkg;

  localparam int unsigned DSP_DATA_W_DEF   = 32;
  localparam int unsigned DSP_STATUS_W_DEF = 1;
  localparam int unsigned DSP_DEPTH_DEF    = 2;

  // Width needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_status_pipe_hs_if.sv
// Handshake bus for data_status_pipe_hs: upstream beat, downstream beat, flush.
// master = the side driving beats in and accepting beats out (environment).
// slave  = the pipeline itself.
interface data_status_pipe_hs_if
  import data_status_pipe_hs_pkg::*;
#(
  parameter int unsigned DATA_W   = DSP_DATA_W_DEF,
  parameter int unsigned STATUS_W = DSP_STATUS_W_DEF
) ();

  logic                flush_i;
  logic                valid_i;
  logic                ready_o;
  logic [DATA_W-1:0]   data_i;
  logic [STATUS_W-1:0] status_i;
  logic                valid_o;
  logic                ready_i;
  logic [DATA_W-1:0]   data_o;
  logic [STATUS_W-1:0] status_o;

  modport master (
    output flush_i, valid_i, data_i, status_i, ready_i,
    input  ready_o, valid_o, data_o, status_o
  );

  modport slave (
    input  flush_i, valid_i, data_i, status_i, ready_i,
    output ready_o, valid_o, data_o, status_o
  );

endinterface

// File: rtl/data_status_pipe_hs_stage.sv
// One pipeline stage: valid (async reset, sync flush), data (no reset),
// status (async reset to STATUS_RST_VAL). Loads the upstream beat when adv.
// Ports: clk, rst, flush, adv, up_valid/up_data/up_status in;
//        valid/data/status out (all registered).
module data_status_pipe_hs_stage
  import data_status_pipe_hs_pkg::*;
#(
  parameter int unsigned         DATA_W         = DSP_DATA_W_DEF,
  parameter int unsigned         STATUS_W       = DSP_STATUS_W_DEF,
  parameter logic [STATUS_W-1:0] STATUS_RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                adv,
  input  logic                up_valid,
  input  logic [DATA_W-1:0]   up_data,
  input  logic [STATUS_W-1:0] up_status,
  output logic                valid,
  output logic [DATA_W-1:0]   data,
  output logic [STATUS_W-1:0] status
);

  // Valid follows upstream whenever the stage advances; flush empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
    end
  end

  // Payload only moves with a real beat, so bubbles leave stale data behind.
  always_ff @(posedge clk) begin
    if (adv && up_valid) begin
      data <= up_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= STATUS_RST_VAL;
    end else if (adv && up_valid) begin
      status <= up_status;
    end
  end

endmodule

// File: rtl/data_status_pipe_hs.sv
// Valid/ready data+status pipeline of PIPE_DEPTH stages with bubble
// collapsing, per-stage taps, flush and an occupancy counter.
// Ports: clk, rst (async, active-high); bus (slave modport: flush, input
// beat, output beat); tap_valid_o/tap_data_o/tap_status_o per tap (tap 0 is
// the live input when INCLUDE_DATA_IN=1); occupancy_o = valid stage count.
module data_status_pipe_hs
  import data_status_pipe_hs_pkg::*;
#(
  parameter int unsigned         DATA_W          = DSP_DATA_W_DEF,
  parameter int unsigned         STATUS_W        = DSP_STATUS_W_DEF,
  parameter int unsigned         PIPE_DEPTH      = DSP_DEPTH_DEF,
  parameter int unsigned         INCLUDE_DATA_IN = 0,
  parameter logic [STATUS_W-1:0] STATUS_RST_VAL  = '0,
  localparam int unsigned        TAPS            = PIPE_DEPTH + INCLUDE_DATA_IN,
  localparam int unsigned        OCC_W           = occ_width(PIPE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  data_status_pipe_hs_if.slave  bus,
  output logic                  tap_valid_o  [TAPS],
  output logic [DATA_W-1:0]     tap_data_o   [TAPS],
  output logic [STATUS_W-1:0]   tap_status_o [TAPS],
  output logic [OCC_W-1:0]      occupancy_o
);

  logic [PIPE_DEPTH-1:0] v;
  logic [PIPE_DEPTH-1:0] adv;
  logic [DATA_W-1:0]     sd [PIPE_DEPTH];
  logic [STATUS_W-1:0]   ss [PIPE_DEPTH];
  logic                  in_acc_c;
  logic                  out_acc_c;

  // Advance chain: a stage may load if it is empty or everything ahead moves.
  always_comb begin
    adv = '0;
    adv[PIPE_DEPTH-1] = bus.ready_i | ~v[PIPE_DEPTH-1];
    for (int k = int'(PIPE_DEPTH) - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~v[k];
    end
  end

  assign bus.ready_o = adv[0] & ~rst;
  assign in_acc_c    = bus.valid_i & bus.ready_o;
  assign out_acc_c   = v[PIPE_DEPTH-1] & bus.ready_i;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic                up_v;
    logic [DATA_W-1:0]   up_d;
    logic [STATUS_W-1:0] up_s;

    if (k == 0) begin : g_head
      assign up_v = bus.valid_i;
      assign up_d = bus.data_i;
      assign up_s = bus.status_i;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_d = sd[k-1];
      assign up_s = ss[k-1];
    end

    data_status_pipe_hs_stage #(
      .DATA_W         (DATA_W),
      .STATUS_W       (STATUS_W),
      .STATUS_RST_VAL (STATUS_RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush_i),
      .adv       (adv[k]),
      .up_valid  (up_v),
      .up_data   (up_d),
      .up_status (up_s),
      .valid     (v[k]),
      .data      (sd[k]),
      .status    (ss[k])
    );
  end

  assign bus.valid_o  = v[PIPE_DEPTH-1];
  assign bus.data_o   = sd[PIPE_DEPTH-1];
  assign bus.status_o = ss[PIPE_DEPTH-1];

  // Occupancy tracks popcount(v); flush wins over any same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy_o <= '0;
    end else if (bus.flush_i) begin
      occupancy_o <= '0;
    end else if (in_acc_c && !out_acc_c) begin
      occupancy_o <= occupancy_o + OCC_W'(1);
    end else if (!in_acc_c && out_acc_c) begin
      occupancy_o <= occupancy_o - OCC_W'(1);
    end
  end

  // Tap i shows stage i-INCLUDE_DATA_IN; optional tap 0 is the live input.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    if (INCLUDE_DATA_IN != 0 && t == 0) begin : g_live
      assign tap_valid_o[t]  = bus.valid_i;
      assign tap_data_o[t]   = bus.data_i;
      assign tap_status_o[t] = bus.status_i;
    end else begin : g_reg
      assign tap_valid_o[t]  = v[t-INCLUDE_DATA_IN];
      assign tap_data_o[t]   = sd[t-INCLUDE_DATA_IN];
      assign tap_status_o[t] = ss[t-INCLUDE_DATA_IN];
    end
  end

endmodule

// File: tb/tb_data_status_pipe_hs.sv
// Randomized + directed bench for data_status_pipe_hs. Reference model keeps
// a queue of in-flight beats with their stage positions.
module tb_data_status_pipe_hs;

  localparam int unsigned DW   = 16;
  localparam int unsigned SW   = 2;
  localparam int          D    = 4;
  localparam int          INC  = 1;
  localparam int          TAPS = D + INC;
  localparam int unsigned OCCW = $clog2(D + 1);
  localparam logic [SW-1:0] RSTV = 2'b10;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int            pos;
  } beat_t;

  logic clk;
  logic rst;
  logic            tap_valid  [TAPS];
  logic [DW-1:0]   tap_data   [TAPS];
  logic [SW-1:0]   tap_status [TAPS];
  logic [OCCW-1:0] occupancy;

  int    n_checks;
  int    n_err;
  beat_t q[$];
  int    seq;

  data_status_pipe_hs_if #(.DATA_W(DW), .STATUS_W(SW)) bus ();

  data_status_pipe_hs #(
    .DATA_W          (DW),
    .STATUS_W        (SW),
    .PIPE_DEPTH      (D),
    .INCLUDE_DATA_IN (INC),
    .STATUS_RST_VAL  (RSTV)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tap_valid_o  (tap_valid),
    .tap_data_o   (tap_data),
    .tap_status_o (tap_status),
    .occupancy_o  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int find_pos(input int p);
    foreach (q[i]) if (q[i].pos == p) return i;
    return -1;
  endfunction

  // Compare every observable against the model (inputs already applied).
  task automatic check_all();
    int idx;
    chk("ready_o", 32'(bus.ready_o), 32'(bus.ready_i || q.size() < D));
    idx = find_pos(D - 1);
    chk("valid_o", 32'(bus.valid_o), 32'(idx >= 0));
    if (idx >= 0) begin
      chk("data_o", 32'(bus.data_o), 32'(q[idx].d));
      chk("status_o", 32'(bus.status_o), 32'(q[idx].s));
    end
    chk("occupancy_o", 32'(occupancy), 32'(q.size()));
    chk("tap_valid[0]", 32'(tap_valid[0]), 32'(bus.valid_i));
    chk("tap_data[0]", 32'(tap_data[0]), 32'(bus.data_i));
    chk("tap_status[0]", 32'(tap_status[0]), 32'(bus.status_i));
    for (int t = INC; t < TAPS; t++) begin
      idx = find_pos(t - INC);
      chk($sformatf("tap_valid[%0d]", t), 32'(tap_valid[t]), 32'(idx >= 0));
      if (idx >= 0) begin
        chk($sformatf("tap_data[%0d]", t), 32'(tap_data[t]), 32'(q[idx].d));
        chk($sformatf("tap_status[%0d]", t), 32'(tap_status[t]), 32'(q[idx].s));
      end
    end
  endtask

  // Move the model across one clock edge: beats slide toward the output
  // into any gap or behind a beat that moved; the front beat leaves when ready.
  task automatic model_step();
    beat_t nq[$];
    bit    acc;
    bit    prev_moved;
    int    prev_pos;
    acc        = bus.valid_i && (bus.ready_i || q.size() < D);
    prev_moved = 1'b0;
    prev_pos   = 0;
    foreach (q[i]) begin
      beat_t b;
      bit    mv;
      b = q[i];
      if (i == 0) mv = (b.pos < D - 1) || bus.ready_i;
      else        mv = (b.pos + 1 < prev_pos) || prev_moved;
      prev_pos   = b.pos;
      prev_moved = mv;
      if (mv) b.pos++;
      if (b.pos < D) nq.push_back(b);
    end
    if (acc) nq.push_back('{d: bus.data_i, s: bus.status_i, pos: 0});
    if (bus.flush_i) nq.delete();
    q = nq;
  endtask

  task automatic cycle(input bit vin, input bit rin, input bit fl,
                       input logic [DW-1:0] din, input logic [SW-1:0] sin);
    @(negedge clk);
    bus.valid_i  = vin;
    bus.ready_i  = rin;
    bus.flush_i  = fl;
    bus.data_i   = din;
    bus.status_i = sin;
    #2;
    check_all();
    model_step();
  endtask

  task automatic beat(input bit rin);
    cycle(1'b1, rin, 1'b0, DW'(seq), SW'(seq));
    seq++;
  endtask

  task automatic idle(input bit rin, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rin, 1'b0, DW'(16'hdead), SW'(0));
  endtask

  // Reset asserted between edges must clear state without waiting for clk.
  task automatic async_reset();
    @(negedge clk);
    bus.valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst valid_o", 32'(bus.valid_o), 32'(0));
    chk("rst ready_o", 32'(bus.ready_o), 32'(0));
    chk("rst occupancy", 32'(occupancy), 32'(0));
    chk("rst status_o", 32'(bus.status_o), 32'(RSTV));
    for (int t = INC; t < TAPS; t++) begin
      chk($sformatf("rst tap_valid[%0d]", t), 32'(tap_valid[t]), 32'(0));
      chk($sformatf("rst tap_status[%0d]", t), 32'(tap_status[t]), 32'(RSTV));
    end
    q.delete();
    @(posedge clk);
    #1;
    chk("rst hold valid_o", 32'(bus.valid_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    seq      = 0;
    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b1;
    bus.flush_i  = 1'b0;
    bus.data_i   = '0;
    bus.status_i = '0;

    // Reset values
    @(negedge clk);
    #2;
    chk("reset ready_o", 32'(bus.ready_o), 32'(0));
    chk("reset valid_o", 32'(bus.valid_o), 32'(0));
    chk("reset occupancy", 32'(occupancy), 32'(0));
    chk("reset status_o", 32'(bus.status_o), 32'(RSTV));
    rst = 1'b0;
    #1;
    chk("release ready_o", 32'(bus.ready_o), 32'(1));

    // Stream 10 beats at full rate
    for (int i = 0; i < 10; i++) beat(1'b1);
    idle(1'b1, D + 1);

    // Bubble collapse with stalled output, then fill until ready_o drops
    cycle(1'b1, 1'b0, 1'b0, DW'(16'h000a), SW'(1));
    idle(1'b0, 1);
    cycle(1'b1, 1'b0, 1'b0, DW'(16'h000b), SW'(2));
    idle(1'b0, 3);
    chk("bubble occupancy", 32'(occupancy), 32'(2));
    for (int i = 0; i < 4; i++) beat(1'b0);
    idle(1'b1, D + 1);

    // Full pipe with simultaneous accept and emit
    for (int i = 0; i < D; i++) beat(1'b0);
    for (int i = 0; i < 5; i++) beat(1'b1);
    idle(1'b1, D + 1);

    // Flush with 3 held and an input accepted in the same cycle
    for (int i = 0; i < 3; i++) beat(1'b0);
    cycle(1'b1, 1'b0, 1'b1, DW'(16'hbeef), SW'(3));
    idle(1'b1, D + 1);

    // Live input tap and first stage tap
    cycle(1'b1, 1'b0, 1'b0, DW'(16'h0055), SW'(1));
    idle(1'b1, D + 1);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0), DW'($urandom), SW'($urandom));
    end

    // Asynchronous reset while full, then resume
    for (int i = 0; i < D; i++) beat(1'b0);
    async_reset();
    for (int i = 0; i < 6; i++) beat(1'b1);
    idle(1'b1, D + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
